// File: rtl/handshake_protocol_monitor.sv
// Multi-channel req/ack handshake monitor: synchronises asynchronous handshakes,
// checks them in four- or two-phase mode, flags protocol errors and counts completions.
module handshake_protocol_monitor #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 8,
    parameter int CNT_W       = 16,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 mode_2ph,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 clr,
    input  logic [NCH-1:0]       req,
    input  logic [NCH-1:0]       ack,
    output logic [NCH-1:0]       err_pulse,
    output logic [NCH-1:0]       err_sticky,
    output logic                 first_err_valid,
    output logic [CH_W-1:0]      first_err_ch,
    output logic [2:0]           first_err_code,
    output logic [CNT_W-1:0]     hs_count
);

    localparam int SUM_W = CNT_W + $clog2(NCH + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    localparam logic [2:0] E_ACK_WITHOUT_REQ = 3'd1;
    localparam logic [2:0] E_REQ_EARLY_FALL  = 3'd2;
    localparam logic [2:0] E_ACK_EARLY_FALL  = 3'd3;
    localparam logic [2:0] E_REQ_EARLY_RISE  = 3'd4;
    localparam logic [2:0] E_SIMULTANEOUS    = 3'd5;
    localparam logic [2:0] E_TIMEOUT         = 3'd6;

    // Two-phase mode reuses the encodings: ST_IDLE means NOTPEND, ST_REQ means PEND.
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK, ST_REL} state_t;

    logic [SYNC_STAGES-1:0][NCH-1:0] req_sync;
    logic [SYNC_STAGES-1:0][NCH-1:0] ack_sync;
    logic [NCH-1:0]                  sreq, sack, preq, pack;
    logic [NCH-1:0]                  req_chg, ack_chg;
    logic [SYNC_STAGES:0]            fill;
    logic                            active;

    state_t               state     [NCH];
    state_t               state_nxt [NCH];
    logic [TIMEOUT_W-1:0] tcnt      [NCH];
    logic [2:0]           err_code  [NCH];
    logic [NCH-1:0]       err_det, done, tmo_hit;
    logic [CH_W-1:0]      low_ch;
    logic [2:0]           low_code;
    logic [SUM_W-1:0]     hs_sum;

    function automatic state_t resync(input logic r, input logic a, input logic two_phase);
        state_t s;
        if (two_phase) begin
            s = (r != a) ? ST_REQ : ST_IDLE;
        end else begin
            case ({r, a})
                2'b10:   s = ST_REQ;
                2'b11:   s = ST_ACK;
                2'b01:   s = ST_REL;
                default: s = ST_IDLE;
            endcase
        end
        return s;
    endfunction

    // fill marks when both the current and previous samples hold post-reset data,
    // so stale lines seen right after reset are absorbed instead of flagged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_sync <= '0;
            ack_sync <= '0;
            preq     <= '0;
            pack     <= '0;
            fill     <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req};
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
            preq     <= sreq;
            pack     <= sack;
            fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sreq    = req_sync[SYNC_STAGES-1];
    assign sack    = ack_sync[SYNC_STAGES-1];
    assign req_chg = sreq ^ preq;
    assign ack_chg = sack ^ pack;
    assign active  = en & fill[SYNC_STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) state[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < NCH; i++) state[i] <= state_nxt[i];
        end
    end

    // Every legal move and every error recovery lands on the state named by the new samples.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_nxt[i] = state[i];
            if (!active || req_chg[i] || ack_chg[i])
                state_nxt[i] = resync(sreq[i], sack[i], mode_2ph);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            err_code[i] = 3'd0;
            done[i]     = 1'b0;
            if (active) begin
                if (req_chg[i] && ack_chg[i]) begin
                    err_code[i] = E_SIMULTANEOUS;
                end else if (mode_2ph) begin
                    if (state[i] == ST_IDLE) begin
                        if (ack_chg[i]) err_code[i] = E_ACK_WITHOUT_REQ;
                    end else if (req_chg[i]) begin
                        err_code[i] = E_REQ_EARLY_RISE;
                    end else if (ack_chg[i]) begin
                        done[i] = 1'b1;
                    end
                end else begin
                    case (state[i])
                        ST_IDLE: if (ack_chg[i]) err_code[i] = E_ACK_WITHOUT_REQ;
                        ST_REQ:  if (req_chg[i]) err_code[i] = E_REQ_EARLY_FALL;
                        ST_ACK:  if (ack_chg[i]) err_code[i] = E_ACK_EARLY_FALL;
                        ST_REL: begin
                            if (req_chg[i])      err_code[i] = E_REQ_EARLY_RISE;
                            else if (ack_chg[i]) done[i] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (tmo_hit[i]) err_code[i] = E_TIMEOUT;
            end
            err_det[i] = (err_code[i] != 3'd0);
        end
    end

    // A stall fires only on the step into the limit with no transition that cycle.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tmo_hit[i] = active && !req_chg[i] && !ack_chg[i] && (state[i] != ST_IDLE) &&
                         (timeout_limit != '0) && (tcnt[i] == timeout_limit - TIMEOUT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) tcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!active || req_chg[i] || ack_chg[i] || state[i] == ST_IDLE)
                    tcnt[i] <= '0;
                else if ((timeout_limit == '0) ? (tcnt[i] != '1) : (tcnt[i] < timeout_limit))
                    tcnt[i] <= tcnt[i] + TIMEOUT_W'(1);
            end
        end
    end

    always_comb begin
        low_ch   = '0;
        low_code = 3'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (err_det[i]) begin
                low_ch   = CH_W'(i);
                low_code = err_code[i];
            end
        end
    end

    always_comb begin
        hs_sum = clr ? '0 : {{(SUM_W-CNT_W){1'b0}}, hs_count};
        for (int i = 0; i < NCH; i++) hs_sum = hs_sum + SUM_W'(done[i]);
        if (hs_sum > CNT_MAX) hs_sum = CNT_MAX;
    end

    // clr acts first, so an error in the same cycle is recorded into the cleared state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_pulse       <= '0;
            err_sticky      <= '0;
            first_err_valid <= 1'b0;
            first_err_ch    <= '0;
            first_err_code  <= 3'd0;
            hs_count        <= '0;
        end else begin
            err_pulse  <= err_det;
            err_sticky <= (clr ? '0 : err_sticky) | err_det;
            hs_count   <= hs_sum[CNT_W-1:0];
            if ((clr || !first_err_valid) && (|err_det)) begin
                first_err_valid <= 1'b1;
                first_err_ch    <= low_ch;
                first_err_code  <= low_code;
            end else if (clr) begin
                first_err_valid <= 1'b0;
                first_err_ch    <= '0;
                first_err_code  <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Self-checking bench for handshake_protocol_monitor: a vector table plus directed
// sequences for timeout, two-phase mode, enable, reset, saturation and clear.
module tb_handshake_protocol_monitor;

    logic       clk = 1'b0;
    logic       rstn, en, mode_2ph, clr;
    logic [7:0] timeout_limit;
    logic [3:0] req, ack;
    logic [3:0] err_pulse, err_sticky;
    logic       first_err_valid;
    logic [1:0] first_err_ch;
    logic [2:0] first_err_code;
    logic [3:0] hs_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
        logic       clr;
        logic [3:0] pulse;
        logic [3:0] sticky;
        logic       valid;
        logic [1:0] ch;
        logic [2:0] code;
        logic [3:0] hs;
    } vec_t;

    vec_t vecs [18];

    handshake_protocol_monitor #(
        .NCH(4), .SYNC_STAGES(2), .TIMEOUT_W(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .mode_2ph(mode_2ph),
        .timeout_limit(timeout_limit), .clr(clr), .req(req), .ack(ack),
        .err_pulse(err_pulse), .err_sticky(err_sticky),
        .first_err_valid(first_err_valid), .first_err_ch(first_err_ch),
        .first_err_code(first_err_code), .hs_count(hs_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkSignal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] e_pulse, input logic [3:0] e_sticky,
                               input logic e_valid, input logic [1:0] e_ch, input logic [2:0] e_code,
                               input logic [3:0] e_hs);
        checkSignal({tag, ".err_pulse"},       32'(err_pulse),       32'(e_pulse));
        checkSignal({tag, ".err_sticky"},      32'(err_sticky),      32'(e_sticky));
        checkSignal({tag, ".first_err_valid"}, 32'(first_err_valid), 32'(e_valid));
        checkSignal({tag, ".first_err_ch"},    32'(first_err_ch),    32'(e_ch));
        checkSignal({tag, ".first_err_code"},  32'(first_err_code),  32'(e_code));
        checkSignal({tag, ".hs_count"},        32'(hs_count),        32'(e_hs));
    endtask

    // Drive new line levels (clr for one cycle) and wait out the synchroniser plus one edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] a, input logic c);
        req = r;
        ack = a;
        clr = c;
        tick(1);
        clr = 1'b0;
        tick(2);
    endtask

    task automatic runHandshake(input int ch);
        logic [3:0] b;
        b = 4'b0001 << ch;
        applyStimulus(req | b, ack, 1'b0);
        applyStimulus(req, ack | b, 1'b0);
        applyStimulus(req & ~b, ack, 1'b0);
        applyStimulus(req, ack & ~b, 1'b0);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; mode_2ph = 1'b0; clr = 1'b0;
        timeout_limit = 8'd20; req = '0; ack = '0;

        //           req      ack    clr   pulse    sticky  vld  ch  code hs
        vecs[0]  = '{4'b0000, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 3'd1, 4'd10};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 3'd1, 4'd11};
        vecs[2]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 3'd1, 4'd11};
        vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 3'd1, 4'd11};
        vecs[4]  = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 3'd1, 4'd11};
        vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1, 2'd2, 3'd1, 4'd12};
        vecs[6]  = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 3'd0, 4'd0};
        vecs[7]  = '{4'b1000, 4'b1000, 1'b0, 4'b1010, 4'b1010, 1'b1, 2'd1, 3'd2, 4'd0};
        vecs[8]  = '{4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b1010, 1'b1, 2'd1, 3'd2, 4'd0};
        vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1010, 1'b1, 2'd1, 3'd2, 4'd1};
        vecs[10] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b1010, 1'b1, 2'd1, 3'd2, 4'd1};
        vecs[11] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b1010, 1'b1, 2'd1, 3'd2, 4'd1};
        vecs[12] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b1011, 1'b1, 2'd1, 3'd2, 4'd1};
        vecs[13] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b1011, 1'b1, 2'd1, 3'd2, 4'd1};
        vecs[14] = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b1011, 1'b1, 2'd1, 3'd2, 4'd1};
        vecs[15] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b1011, 1'b1, 2'd1, 3'd2, 4'd1};
        vecs[16] = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b1011, 1'b1, 2'd1, 3'd2, 4'd1};
        vecs[17] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1011, 1'b1, 2'd1, 3'd2, 4'd2};

        tick(3);
        checkOutput("reset", 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, 4'd0);
        rstn = 1'b1;
        tick(4);
        en = 1'b1;
        tick(1);

        $display("[TB] four-phase: 10 legal handshakes on channel 0");
        for (int n = 0; n < 10; n++) runHandshake(0);
        checkOutput("fourphase_x10", 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, 4'd10);

        $display("[TB] vector table");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].req, vecs[i].ack, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].pulse, vecs[i].sticky,
                        vecs[i].valid, vecs[i].ch, vecs[i].code, vecs[i].hs);
        end

        $display("[TB] timeout: limit 5, req stalls without ack");
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        timeout_limit = 8'd5;
        req = 4'b0001;
        for (int c = 1; c <= 7; c++) begin
            tick(1);
            checkSignal($sformatf("timeout_quiet%0d.err_pulse", c), 32'(err_pulse), 32'd0);
        end
        tick(1);
        checkOutput("timeout_fire", 4'b0001, 4'b0001, 1'b1, 2'd0, 3'd6, 4'd0);
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            checkSignal($sformatf("timeout_hold%0d.err_pulse", c), 32'(err_pulse), 32'd0);
        end
        applyStimulus(4'b0001, 4'b0001, 1'b0);
        checkOutput("timeout_ack", 4'b0, 4'b0001, 1'b1, 2'd0, 3'd6, 4'd0);
        applyStimulus(4'b0000, 4'b0001, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("timeout_done", 4'b0, 4'b0001, 1'b1, 2'd0, 3'd6, 4'd1);

        $display("[TB] timeout: ack lands on the limit cycle");
        req = 4'b0010;
        tick(5);
        ack = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick(1);
            checkSignal($sformatf("timeout_race%0d.err_pulse", c), 32'(err_pulse), 32'd0);
        end
        applyStimulus(4'b0000, 4'b0010, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("timeout_race_done", 4'b0, 4'b0001, 1'b1, 2'd0, 3'd6, 4'd2);

        $display("[TB] two-phase mode");
        en = 1'b0;
        mode_2ph = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        en = 1'b1;
        tick(1);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        checkOutput("2ph_pend", 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, 4'd0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("2ph_req_twice", 4'b0001, 4'b0001, 1'b1, 2'd0, 3'd4, 4'd0);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 1'b0);
        applyStimulus(4'b0000, 4'b0001, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 1'b0);
        checkOutput("2ph_pairs", 4'b0, 4'b0001, 1'b1, 2'd0, 3'd4, 4'd3);
        applyStimulus(4'b0001, 4'b0011, 1'b0);
        checkOutput("2ph_ack_first", 4'b0010, 4'b0011, 1'b1, 2'd0, 3'd4, 4'd3);
        applyStimulus(4'b0001, 4'b0001, 1'b0);
        checkOutput("2ph_recover", 4'b0, 4'b0011, 1'b1, 2'd0, 3'd4, 4'd4);

        $display("[TB] enable low: resync only");
        en = 1'b0;
        mode_2ph = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("en_off", 4'b0, 4'b0011, 1'b1, 2'd0, 3'd4, 4'd4);
        applyStimulus(4'b0000, 4'b1000, 1'b0);
        checkOutput("en_off_bad_ack", 4'b0, 4'b0011, 1'b1, 2'd0, 3'd4, 4'd4);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        en = 1'b1;
        tick(1);

        $display("[TB] reset mid-handshake");
        timeout_limit = 8'd20;
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        #2 rstn = 1'b0;
        #1 checkOutput("reset_async", 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, 4'd0);
        tick(2);
        rstn = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            checkSignal($sformatf("reset_quiet%0d.err_pulse", c), 32'(err_pulse), 32'd0);
        end
        checkOutput("reset_release", 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, 4'd0);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        applyStimulus(4'b0000, 4'b0100, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("reset_resume", 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, 4'd1);

        $display("[TB] saturation and clear");
        timeout_limit = 8'd0;
        for (int n = 0; n < 20; n++) runHandshake(0);
        checkOutput("saturate", 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, 4'd15);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        ack = 4'b0000;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        checkOutput("clr_with_err", 4'b0010, 4'b0010, 1'b1, 2'd1, 3'd3, 4'd0);
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        applyStimulus(4'b0111, 4'b0010, 1'b0);
        applyStimulus(4'b0111, 4'b0111, 1'b0);
        applyStimulus(4'b0000, 4'b0111, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("parallel3", 4'b0, 4'b0010, 1'b1, 2'd1, 3'd3, 4'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_protocol_monitor.md
Name: handshake_protocol_monitor

Overview:
- Clocked, parametrised, multi-channel protocol checker for req/ack handshakes between self-timed blocks and the synchronous test environment.
- Synchronises NCH asynchronous req/ack pairs and tracks each channel with its own state machine.
- Supports four-phase (return-to-zero) or two-phase (transition) signalling, flags illegal transitions and stalls as error codes, and counts completed handshakes.
- Used in testbenches and as on-chip debug logic alongside async pipelines.

Parameters:
- NCH, 4: number of monitored req/ack channels.
- SYNC_STAGES, 2: flip-flop synchroniser depth per req/ack bit; minimum 2.
- TIMEOUT_W, 8: width of the stall limit and of the per-channel stall counters.
- CNT_W, 16: width of the completed-handshake counter.

Ports:
- clk  input  1  monitor clock.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  1 = checking active. 0 = resynchronise only; no errors, no counting.
- mode_2ph  input  1  0 = four-phase, 1 = two-phase. Changed only while en=0.
- timeout_limit  input  TIMEOUT_W  stall limit in clk cycles; 0 disables timeout checks.
- clr  input  1  clears sticky errors, the first-error capture and hs_count.
- req  input  NCH  asynchronous request lines.
- ack  input  NCH  asynchronous acknowledge lines.
- err_pulse  output  NCH  one-cycle pulse per channel when that channel detects an error.
- err_sticky  output  NCH  latched per-channel error flags.
- first_err_valid  output  1  first-error record is valid.
- first_err_ch  output  clog2(NCH), minimum 1  channel of the first error.
- first_err_code  output  3  code of the first error.
- hs_count  output  CNT_W  saturating count of completed handshakes, all channels.

Behaviour:
- Reset (rstn=0, asynchronous): all outputs, synchroniser flops, FSMs and counters go to 0. Each FSM enters IDLE, or NOTPEND in two-phase mode.
- Sampling: each bit passes through SYNC_STAGES flops giving sreq/sack, and the previous sample is kept.
  - A change is a difference between the current and previous sample.
  - err_pulse rises SYNC_STAGES+1 clk edges after the offending input edge.
- Error codes:
  - 1 ACK_WITHOUT_REQ
  - 2 REQ_EARLY_FALL
  - 3 ACK_EARLY_FALL
  - 4 REQ_EARLY_RISE
  - 5 SIMULTANEOUS (req and ack change in the same sample)
  - 6 TIMEOUT
  - 0 and 7 unused.
- Four-phase FSM per channel:
  - IDLE(0,0): sreq rise -> REQ; sack rise -> error 1.
  - REQ(1,0): sack rise -> ACK; sreq fall -> error 2.
  - ACK(1,1): sreq fall -> REL; sack fall -> error 3.
  - REL(0,1): sack fall -> IDLE and hs_count+1; sreq rise -> error 4.
  - Both change in one sample -> error 5.
  - After any error the FSM resyncs to the state named by the current (sreq,sack).
- Two-phase FSM per channel:
  - NOTPEND (sreq==sack): sreq toggle -> PEND; sack toggle -> error 1.
  - PEND: sack toggle -> NOTPEND and hs_count+1; sreq toggle -> error 4.
  - Simultaneous toggle -> error 5.
  - After an error the FSM resyncs to PEND if sreq!=sack, else NOTPEND.
- Timeout:
  - Each channel's counter runs while its FSM is not in IDLE/NOTPEND and resets on any legal transition.
  - When timeout_limit!=0 and the counter reaches timeout_limit, error 6 fires once.
  - The counter then holds until the next transition, so there is no repeat pulse.
  - A transition in the same cycle as the limit wins: no error 6.
- Error recording:
  - err_pulse[i] is high for exactly one cycle per error and sets err_sticky[i].
  - first_err_* captures the first error while first_err_valid=0.
  - Simultaneous errors on several channels: the lowest channel index is captured.
- clr and a new error in the same cycle: clear first, then record. The sticky flag is set, the new error is captured and hs_count becomes 0.
- hs_count saturates at 2^CNT_W-1. Simultaneous completions on k channels add k, clamped at saturation.
- en=0: FSMs resync every cycle from the current samples; stall counters are held at 0; no err_pulse; hs_count is held.
  - Sticky flags and the first-error record are kept.
  - Checking restarts on the cycle en rises.
- Reset mid-handshake: state is discarded. After release, the first samples are taken as the previous state and no error is raised on stale lines.

Test Plan:
- Four-phase legal sequence, 10 handshakes on channel 0, en=1, limit=20 -> hs_count=10, err_sticky=0, first_err_valid=0.
- Four-phase ch2: ack rises with req=0 -> err_pulse[2] for 1 cycle, first_err_ch=2, code=1; a later legal handshake increments hs_count.
- Same sample: ch1 drops req early (code 2) and ch3 raises ack and req together (code 5) -> err_sticky=4'b1010, first_err_ch=1, code=2.
- Timeout: limit=5, req held high with no ack -> code 6 exactly once, 5 cycles after the synchronised req; ack then arrives -> no further error.
- Two-phase mode (en=0, set mode_2ph=1, en=1): req toggles twice without ack -> code 4; 3 legal toggle pairs -> hs_count=3.
- Reset and clear: rstn pulsed low mid-handshake -> all outputs 0, no spurious error after release; CNT_W=4 with 20 handshakes -> hs_count=15; clr coincident with a code-3 error -> first_err_code=3, hs_count=0.
